// File: rtl/paridade_8b_pkg.sv
// Package paridade_pkg: shared constants and helpers for the parity generator.
//   PARIDADE_WIDTH_DEF : default data word width
//   PARIDADE_EVEN      : ODD parameter value selecting even parity
//   PARIDADE_ODD       : ODD parameter value selecting odd parity
//   parity_f(data)     : XOR reduction of a word up to 64 bits (zero-extend
//                        narrower words; zero padding does not alter parity)
package paridade_pkg;

  localparam int PARIDADE_WIDTH_DEF = 8;
  localparam int PARIDADE_EVEN      = 0;
  localparam int PARIDADE_ODD       = 1;

  function automatic logic parity_f(input logic [63:0] data);
    return ^data;
  endfunction

endpackage : paridade_pkg

// File: rtl/paridade_8b_if.sv
// Interface paridade_8b_if: data/parity bus of the registered parity generator.
//   data_in    : WIDTH-bit word, driven by the master
//   parity_out : registered parity, driven by the slave (the generator)
//   valid_in   : data_in qualifier      (only when PARIDADE_VALID_EN is defined)
//   valid_out  : parity_out qualifier   (only when PARIDADE_VALID_EN is defined)
// Modports: master (data source / parity consumer), slave (parity generator).
interface paridade_8b_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             parity_out;

`ifdef PARIDADE_VALID_EN
  logic valid_in;
  logic valid_out;

  modport master (output data_in, output valid_in, input parity_out, input valid_out);
  modport slave  (input data_in, input valid_in, output parity_out, output valid_out);
`else
  modport master (output data_in, input parity_out);
  modport slave  (input data_in, output parity_out);
`endif

endinterface : paridade_8b_if

// File: rtl/paridade_xor_tree.sv
// Module paridade_xor_tree: combinational balanced XOR tree.
//   data   in  WIDTH : word to reduce
//   parity out 1     : XOR of all WIDTH bits (X on any bit propagates)
// The word is padded with zeros up to the next power of two and reduced in a
// heap-ordered binary tree: node i has children 2i+1 and 2i+2, leaves occupy
// nodes LEAVES-1 .. 2*LEAVES-2, and node 0 is the root.
module paridade_xor_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int LEAVES = 1 << LEVELS;

  logic [2*LEAVES-2:0] node;

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < WIDTH) begin : g_bit
        assign node[LEAVES-1+gi] = data[gi];
      end else begin : g_pad
        assign node[LEAVES-1+gi] = 1'b0;
      end
    end
    for (gi = 0; gi < LEAVES-1; gi++) begin : g_node
      assign node[gi] = node[2*gi+1] ^ node[2*gi+2];
    end
  endgenerate

  assign parity = node[0];

endmodule : paridade_xor_tree

// File: rtl/paridade_8b.sv
// Module paridade_8b: registered parity generator.
//   clk  in  : system clock, rising edge
//   rst  in  : asynchronous active-high reset, clears parity_out (and valid_out)
//   bus  slave modport of paridade_8b_if:
//     data_in in WIDTH, parity_out out 1, valid_in/valid_out (optional)
// Parameters: WIDTH (1..64), ODD (0 = even parity, 1 = odd parity).
// Optional feature macro: PARIDADE_VALID_EN -- adds valid_in/valid_out; parity_out
// then updates only on edges with valid_in=1, and valid_out follows valid_in
// with one cycle of latency so it stays aligned with parity_out.
module paridade_8b
  import paridade_pkg::*;
#(
  parameter int WIDTH = PARIDADE_WIDTH_DEF,
  parameter int ODD   = PARIDADE_EVEN
) (
  input  logic         clk,
  input  logic         rst,
  paridade_8b_if.slave bus
);

  localparam logic ODD_BIT = (ODD != PARIDADE_EVEN);

  logic raw_parity;
  logic parity_reg;
  logic parity_next;

  paridade_xor_tree #(
    .WIDTH (WIDTH)
  ) u_xor_tree (
    .data   (bus.data_in),
    .parity (raw_parity)
  );

`ifdef PARIDADE_VALID_EN
  logic valid_reg;
  logic valid_next;

  always_comb begin
    parity_next = parity_reg;
    valid_next  = bus.valid_in;
    if (bus.valid_in) begin
      parity_next = raw_parity ^ ODD_BIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      parity_reg <= parity_next;
      valid_reg  <= valid_next;
    end
  end

  assign bus.valid_out = valid_reg;
`else
  always_comb begin
    parity_next = raw_parity ^ ODD_BIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= parity_next;
    end
  end
`endif

  assign bus.parity_out = parity_reg;

endmodule : paridade_8b

// File: tb/tb_paridade_8b.sv
// Testbench tb_paridade_8b: directed vectors for paridade_8b.
// Two instances: dut_even (ODD=0) and dut_odd (ODD=1), sharing clk and rst.
// Also exercises valid gating when PARIDADE_VALID_EN is defined.
module tb_paridade_8b;
  import paridade_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [7:0] WALK_DATA [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                                           8'h1F, 8'h3F, 8'h7F, 8'hFF};
  localparam logic       WALK_EXP  [8] = '{1'b1, 1'b0, 1'b1, 1'b0,
                                           1'b1, 1'b0, 1'b1, 1'b0};

  paridade_8b_if #(.WIDTH(8)) bus_even ();
  paridade_8b_if #(.WIDTH(8)) bus_odd ();

  paridade_8b #(.WIDTH(8), .ODD(PARIDADE_EVEN)) dut_even (
    .clk (clk),
    .rst (rst),
    .bus (bus_even.slave)
  );

  paridade_8b #(.WIDTH(8), .ODD(PARIDADE_ODD)) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_odd.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_even.data_in = 8'h01;
    bus_odd.data_in  = 8'h00;
    tick();
    vectors++;
    if (bus_even.parity_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre parity_out=%b expected=1", bus_even.parity_out);
    end else $display("ok   reset_pre parity_out=%b", bus_even.parity_out);
    // assert rst mid-cycle: output must clear without a clock edge
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus_even.parity_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async parity_out=%b expected=0", bus_even.parity_out);
    end else $display("ok   reset_async parity_out=%b", bus_even.parity_out);
`ifdef PARIDADE_VALID_EN
    vectors++;
    if (bus_even.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid valid_out=%b expected=0", bus_even.valid_out);
    end else $display("ok   reset_valid valid_out=%b", bus_even.valid_out);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus_even.parity_out !== 1'b0 || bus_odd.parity_out !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d] even=%b odd=%b expected=0/0", i,
                 bus_even.parity_out, bus_odd.parity_out);
      end else $display("ok   reset_hold[%0d] even=%b odd=%b", i,
                        bus_even.parity_out, bus_odd.parity_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_walking_ones();
    for (int i = 0; i < 8; i++) begin
      bus_even.data_in = WALK_DATA[i];
      tick();
      vectors++;
      if (bus_even.parity_out !== WALK_EXP[i]) begin
        miscompares++;
        $display("FAIL walk[%0d] data=%h parity_out=%b expected=%b", i,
                 WALK_DATA[i], bus_even.parity_out, WALK_EXP[i]);
      end else $display("ok   walk[%0d] data=%h parity_out=%b", i,
                        WALK_DATA[i], bus_even.parity_out);
    end
  endtask

  task automatic test_hold();
    bus_even.data_in = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus_even.parity_out !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_edge[%0d] parity_out=%b expected=1", i, bus_even.parity_out);
      end else $display("ok   hold_edge[%0d] parity_out=%b", i, bus_even.parity_out);
      #7;
      vectors++;
      if (bus_even.parity_out !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_mid[%0d] parity_out=%b expected=1", i, bus_even.parity_out);
      end else $display("ok   hold_mid[%0d] parity_out=%b", i, bus_even.parity_out);
    end
  endtask

  task automatic test_odd();
    logic [7:0] odd_data [3];
    logic       odd_exp  [3];
    odd_data = '{8'h00, 8'h01, 8'hFF};
    odd_exp  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus_odd.data_in = odd_data[i];
      tick();
      vectors++;
      if (bus_odd.parity_out !== odd_exp[i]) begin
        miscompares++;
        $display("FAIL odd[%0d] data=%h parity_out=%b expected=%b", i,
                 odd_data[i], bus_odd.parity_out, odd_exp[i]);
      end else $display("ok   odd[%0d] data=%h parity_out=%b", i,
                        odd_data[i], bus_odd.parity_out);
    end
  endtask

  task automatic test_mid_reset();
    // parity_out is 1 from the hold phase; drive 01 then reset before capture
    bus_even.data_in = 8'h01;
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (bus_even.parity_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async parity_out=%b expected=0", bus_even.parity_out);
    end else $display("ok   midrst_async parity_out=%b", bus_even.parity_out);
    tick();
    vectors++;
    if (bus_even.parity_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_edge parity_out=%b expected=0", bus_even.parity_out);
    end else $display("ok   midrst_edge parity_out=%b", bus_even.parity_out);
    #2 rst = 1'b0;
    tick();
    vectors++;
    if (bus_even.parity_out !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_release parity_out=%b expected=1", bus_even.parity_out);
    end else $display("ok   midrst_release parity_out=%b", bus_even.parity_out);
  endtask

`ifdef PARIDADE_VALID_EN
  task automatic test_valid();
    logic [7:0] v_data  [4];
    logic       v_in    [4];
    logic       v_par   [4];
    logic       v_out   [4];
    v_data = '{8'h00, 8'h01, 8'h03, 8'h03};
    v_in   = '{1'b1, 1'b1, 1'b0, 1'b0};
    v_par  = '{1'b0, 1'b1, 1'b1, 1'b1};
    v_out  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus_even.data_in  = v_data[i];
      bus_even.valid_in = v_in[i];
      tick();
      vectors++;
      if (bus_even.parity_out !== v_par[i] || bus_even.valid_out !== v_out[i]) begin
        miscompares++;
        $display("FAIL valid[%0d] data=%h vin=%b parity_out=%b valid_out=%b expected=%b/%b",
                 i, v_data[i], v_in[i], bus_even.parity_out, bus_even.valid_out,
                 v_par[i], v_out[i]);
      end else $display("ok   valid[%0d] data=%h vin=%b parity_out=%b valid_out=%b",
                        i, v_data[i], v_in[i], bus_even.parity_out, bus_even.valid_out);
    end
  endtask
`endif

  initial begin
    bus_even.data_in = 8'h00;
    bus_odd.data_in  = 8'h00;
`ifdef PARIDADE_VALID_EN
    bus_even.valid_in = 1'b1;
    bus_odd.valid_in  = 1'b1;
`endif
    test_reset();
    test_walking_ones();
    test_hold();
    test_odd();
    test_mid_reset();
`ifdef PARIDADE_VALID_EN
    test_valid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_paridade_8b
